// File: rtl/pfpu_f2i_pipe_if.sv
// pfpu_f2i_pipe_if: operand/result bundle between the PFPU sequencer (master)
// and the float-to-fixed converter (slave).
interface pfpu_f2i_pipe_if #(
    parameter int OUT_W = 32
);
    logic [31:0]             a;
    logic                    valid_i;
    logic                    round_i;
    logic signed [OUT_W-1:0] r;
    logic                    valid_o;
    logic                    ovf_o;

    modport master (
        output a, valid_i, round_i,
        input  r, valid_o, ovf_o
    );

    modport slave (
        input  a, valid_i, round_i,
        output r, valid_o, ovf_o
    );
endinterface

// File: rtl/pfpu_f2i_pipe.sv
// pfpu_f2i_pipe: two-stage IEEE-754 single to signed fixed-point converter.
// Stage 1 aligns the mantissa and extracts guard/sticky; stage 2 rounds,
// applies the sign and saturates. Defining PFPU_F2I_FLAGS_EN adds the sticky
// {invalid, overflow} flags_o port.
module pfpu_f2i_pipe #(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 0
) (
    input  logic           sys_clk,
    input  logic           alu_rst,
    pfpu_f2i_pipe_if.slave bus
`ifdef PFPU_F2I_FLAGS_EN
    ,
    output logic [1:0]     flags_o
`endif
);
    // One extra magnitude bit keeps the rounding carry visible.
    localparam int MAG_W = OUT_W + 1;
    localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic [MAG_W-1:0] MIN_MAG = MAG_W'(64'd1 << (OUT_W - 1));
    localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

    // Round-to-nearest-even on the unsigned magnitude; truncation when rnd=0.
    function automatic logic [MAG_W-1:0] round_mag(input logic [MAG_W-1:0] m,
                                                   input logic grd,
                                                   input logic stk,
                                                   input logic rnd);
        logic inc;
        inc = rnd & grd & (stk | m[0]);
        return m + MAG_W'(inc);
    endfunction

    // Apply sign and clamp; returns {ovf, result}. The negative range reaches
    // one step further than the positive one.
    function automatic logic [OUT_W:0] saturate(input logic [MAG_W-1:0] m,
                                                input logic neg,
                                                input logic is_nan,
                                                input logic is_inf,
                                                input logic big_pos,
                                                input logic big_neg);
        logic [OUT_W-1:0] res;
        logic             ovf;
        res = m[OUT_W-1:0];
        ovf = 1'b0;
        if (is_nan) begin
            res = '0;
            ovf = 1'b1;
        end else if (!neg) begin
            if (is_inf || big_pos || (m > MAX_MAG)) begin
                res = POS_SAT;
                ovf = 1'b1;
            end
        end else if (is_inf || big_neg || (m > MIN_MAG)) begin
            res = NEG_SAT;
            ovf = 1'b1;
        end else begin
            res = -m[OUT_W-1:0];
        end
        return {ovf, res};
    endfunction

    logic             sign;
    logic [7:0]       expo;
    logic [22:0]      frac;
    logic [23:0]      mant;
    int               lead;
    int               k;
    logic [5:0]       sh;
    logic [63:0]      rsh;
    logic [MAG_W-1:0] mag;
    logic             grd, stk, zero, nan, inf, pre_ovf, huge;

    // Decode the operand and align the mantissa onto the fixed-point grid.
    always_comb begin
        sign    = bus.a[31];
        expo    = bus.a[30:23];
        frac    = bus.a[22:0];
        mant    = {1'b1, frac};
        lead    = int'({24'd0, expo}) - 127 + FRAC_W;
        k       = int'({24'd0, expo}) - 150 + FRAC_W;
        zero    = (expo == 8'd0);
        nan     = (expo == 8'hFF) && (frac != 23'd0);
        inf     = (expo == 8'hFF) && (frac == 23'd0);
        // pre_ovf: magnitude >= 2^(OUT_W-1); huge: magnitude >= 2^OUT_W,
        // which does not fit the magnitude register even after rounding.
        pre_ovf = !zero && (lead >= OUT_W - 1);
        huge    = !zero && (lead >= OUT_W);
        sh      = '0;
        rsh     = '0;
        mag     = '0;
        grd     = 1'b0;
        stk     = 1'b0;
        if (k >= 0) begin
            sh  = (k > 40) ? 6'd40 : 6'(k);
            mag = MAG_W'({40'd0, mant} << sh);
        end else begin
            // Any shift beyond 25 leaves guard=0 and sticky=1, so 40 is enough.
            sh  = (k < -40) ? 6'd40 : 6'(-k);
            rsh = {mant, 40'd0} >> sh;
            mag = MAG_W'(rsh[63:40]);
            grd = rsh[39];
            stk = |rsh[38:0];
        end
        if (zero) begin
            mag = '0;
            grd = 1'b0;
            stk = 1'b0;
        end
    end

    // ---- stage 1 boundary ----
    logic             vld_p1;
    logic             sign_p1, grd_p1, stk_p1, rnd_p1, nan_p1, inf_p1, pre_ovf_p1, huge_p1;
    logic [MAG_W-1:0] mag_p1;

    // Stage 1 valid: the only stage 1 state that sees reset.
    always_ff @(posedge sys_clk) begin
        if (alu_rst) vld_p1 <= 1'b0;
        else         vld_p1 <= bus.valid_i;
    end

    // Stage 1 data loads every cycle; qualified downstream by vld_p1.
    always_ff @(posedge sys_clk) begin
        sign_p1    <= sign;
        mag_p1     <= mag;
        grd_p1     <= grd;
        stk_p1     <= stk;
        rnd_p1     <= bus.round_i;
        nan_p1     <= nan;
        inf_p1     <= inf;
        pre_ovf_p1 <= pre_ovf;
        huge_p1    <= huge;
    end

    logic [MAG_W-1:0] mag_rnd;
    logic [OUT_W-1:0] res;
    logic             ovf;

    // Round the magnitude, then sign and saturate.
    always_comb begin
        mag_rnd    = round_mag(mag_p1, grd_p1, stk_p1, rnd_p1);
        {ovf, res} = saturate(mag_rnd, sign_p1, nan_p1, inf_p1, pre_ovf_p1, huge_p1);
    end

    // ---- stage 2 boundary ----
    logic             vld_p2, ovf_p2;
    logic [OUT_W-1:0] r_p2;

    // Output register; cleared by reset so the port idles at zero.
    always_ff @(posedge sys_clk) begin
        if (alu_rst) begin
            vld_p2 <= 1'b0;
            r_p2   <= '0;
            ovf_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            r_p2   <= res;
            ovf_p2 <= ovf;
        end
    end

    assign bus.r       = r_p2;
    assign bus.valid_o = vld_p2;
    assign bus.ovf_o   = ovf_p2;

`ifdef PFPU_F2I_FLAGS_EN
    logic [1:0] flags;

    // Sticky flags update on the edge that presents the result; reset wins.
    always_ff @(posedge sys_clk) begin
        if (alu_rst)     flags <= 2'b00;
        else if (vld_p1) flags <= flags | {nan_p1, ovf & ~nan_p1};
    end

    assign flags_o = flags;
`endif
endmodule

// File: tb/tb_pfpu_f2i_pipe.sv
// tb_pfpu_f2i_pipe: random and directed stimulus on two converter builds
// (32.0 and 16.8) checked against an arithmetic reference model.
module tb_pfpu_f2i_pipe;
    logic sys_clk = 1'b0;
    logic alu_rst;
    logic [31:0] a_in;
    logic vld_in;
    logic rnd_in;

    always #5 sys_clk = ~sys_clk;

    pfpu_f2i_pipe_if #(.OUT_W(32)) bus_a ();
    pfpu_f2i_pipe_if #(.OUT_W(16)) bus_b ();

    assign bus_a.a       = a_in;
    assign bus_a.valid_i = vld_in;
    assign bus_a.round_i = rnd_in;
    assign bus_b.a       = a_in;
    assign bus_b.valid_i = vld_in;
    assign bus_b.round_i = rnd_in;

`ifdef PFPU_F2I_FLAGS_EN
    logic [1:0] flags_a, flags_b;
    logic [1:0] fl_a = 2'b00, fl_b = 2'b00;
    pfpu_f2i_pipe #(.OUT_W(32), .FRAC_W(0)) dut_a (
        .sys_clk(sys_clk), .alu_rst(alu_rst), .bus(bus_a), .flags_o(flags_a));
    pfpu_f2i_pipe #(.OUT_W(16), .FRAC_W(8)) dut_b (
        .sys_clk(sys_clk), .alu_rst(alu_rst), .bus(bus_b), .flags_o(flags_b));
`else
    pfpu_f2i_pipe #(.OUT_W(32), .FRAC_W(0)) dut_a (
        .sys_clk(sys_clk), .alu_rst(alu_rst), .bus(bus_a));
    pfpu_f2i_pipe #(.OUT_W(16), .FRAC_W(8)) dut_b (
        .sys_clk(sys_clk), .alu_rst(alu_rst), .bus(bus_b));
`endif

    typedef struct packed {
        logic        nan;
        logic        ovf;
        logic [31:0] r;
    } res_t;

    typedef struct {
        res_t ra;
        res_t rb;
        int   due;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Exact value M*2^k scaled to the output grid, rounded by comparing the
    // discarded remainder against one half LSB, then clamped to the range.
    function automatic res_t ref_conv(input logic [31:0] x, input logic rnd,
                                      input int ow, input int fw);
        res_t        res;
        longint      maxv, minv, m, q_v, rem, half, v;
        int          e, lead, k, sh;
        logic [31:0] mask;
        res  = '0;
        maxv = (longint'(1) <<< (ow - 1)) - 1;
        minv = -maxv - 1;
        mask = (ow == 32) ? 32'hFFFF_FFFF : ((32'd1 << ow) - 32'd1);
        e    = int'({24'd0, x[30:23]});
        if (e == 255 && x[22:0] != 23'd0) begin
            res.nan = 1'b1;
            res.ovf = 1'b1;
            return res;
        end
        if (e == 0) return res;
        if (e == 255) begin
            v = x[31] ? minv - 1 : maxv + 1;
        end else begin
            lead = e - 127 + fw;
            if (lead > 40) begin
                v = x[31] ? minv - 1 : maxv + 1;
            end else begin
                m = longint'({40'd0, 1'b1, x[22:0]});
                k = e - 150 + fw;
                if (k >= 0) begin
                    q_v = m <<< k;
                end else begin
                    sh = -k;
                    if (sh >= 26) begin
                        q_v = 0;
                    end else begin
                        q_v  = m >>> sh;
                        rem  = m - (q_v <<< sh);
                        half = longint'(1) <<< (sh - 1);
                        if (rnd && (rem > half || (rem == half && q_v[0]))) q_v = q_v + 1;
                    end
                end
                v = x[31] ? -q_v : q_v;
            end
        end
        if (v > maxv) begin
            res.ovf = 1'b1;
            v = maxv;
        end else if (v < minv) begin
            res.ovf = 1'b1;
            v = minv;
        end
        res.r = 32'(v) & mask;
        return res;
    endfunction

    // One clock: update the model at the edge, compare at the falling edge.
    task automatic step();
        item_t it;
        item_t nw;
        bit    have;
        @(posedge sys_clk);
        cyc++;
        have = 0;
        if (alu_rst) begin
            q.delete();
`ifdef PFPU_F2I_FLAGS_EN
            fl_a = 2'b00;
            fl_b = 2'b00;
`endif
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                it = q.pop_front();
                have = 1;
`ifdef PFPU_F2I_FLAGS_EN
                fl_a = fl_a | {it.ra.nan, it.ra.ovf & ~it.ra.nan};
                fl_b = fl_b | {it.rb.nan, it.rb.ovf & ~it.rb.nan};
`endif
            end
            if (vld_in) begin
                nw.ra  = ref_conv(a_in, rnd_in, 32, 0);
                nw.rb  = ref_conv(a_in, rnd_in, 16, 8);
                nw.due = cyc + 1;
                q.push_back(nw);
            end
        end
        @(negedge sys_clk);
        check("valid32", 64'(bus_a.valid_o), 64'(have));
        check("valid16", 64'(bus_b.valid_o), 64'(have));
        if (have) begin
            check("r32",   {32'd0, bus_a.r}, {32'd0, it.ra.r});
            check("ovf32", 64'(bus_a.ovf_o), 64'(it.ra.ovf));
            check("r16",   {48'd0, bus_b.r}, {32'd0, it.rb.r});
            check("ovf16", 64'(bus_b.ovf_o), 64'(it.rb.ovf));
        end
`ifdef PFPU_F2I_FLAGS_EN
        check("flags32", 64'(flags_a), 64'(fl_a));
        check("flags16", 64'(flags_b), 64'(fl_b));
`endif
    endtask

    task automatic send(input logic [31:0] x, input logic rd);
        a_in   = x;
        vld_in = 1'b1;
        rnd_in = rd;
        step();
    endtask

    task automatic idle(input int n);
        vld_in = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'hFF;
        else               e = 8'($urandom_range(110, 165));
        f = 23'($urandom);
        if ($urandom_range(0, 3) == 0) f = f & ~23'((32'd1 << $urandom_range(0, 22)) - 32'd1);
        if (sel == 1 && $urandom_range(0, 1) == 0) f = 23'd0;
        return {1'($urandom), e, f};
    endfunction

    initial begin
        alu_rst = 1'b1;
        a_in    = 32'd0;
        vld_in  = 1'b0;
        rnd_in  = 1'b0;
        repeat (3) step();
        check("rst_r32",   {32'd0, bus_a.r}, 64'd0);
        check("rst_ovf32", 64'(bus_a.ovf_o), 64'd0);
        check("rst_r16",   {48'd0, bus_b.r}, 64'd0);
        check("rst_ovf16", 64'(bus_b.ovf_o), 64'd0);
        alu_rst = 1'b0;
        idle(2);

        // Single pulse, then idle so valid_o must drop again.
        send(32'h40490FDB, 1'b0);
        idle(3);

        // Ties and signs, round-nearest-even then truncate, back to back.
        send(32'h40600000, 1'b1);
        send(32'hC0200000, 1'b1);
        send(32'h3F000000, 1'b1);
        send(32'h40600000, 1'b0);
        send(32'hC0200000, 1'b0);
        send(32'h3F000000, 1'b0);
        idle(2);

        // Saturation corners and the 16.8 build corners.
        send(32'h4F000000, 1'b0);
        send(32'hCF000000, 1'b0);
        send(32'hFF800000, 1'b0);
        send(32'h7FC00000, 1'b0);
        send(32'h80000000, 1'b1);
        send(32'h3FC00000, 1'b1);
        send(32'h3B000000, 1'b1);
        send(32'h43000000, 1'b1);
        send(32'hC3000000, 1'b1);
        send(32'hBB400000, 1'b1);
        idle(3);

        // Flag accumulation and clear.
        send(32'h7FC00000, 1'b0);
        send(32'h3F800000, 1'b0);
        idle(3);
        send(32'h4F000000, 1'b0);
        idle(3);
        alu_rst = 1'b1;
        step();
        alu_rst = 1'b0;
        idle(2);

        // Reset in the middle of a stream.
        send(32'h40400000, 1'b0);
        alu_rst = 1'b1;
        send(32'h40800000, 1'b0);
        alu_rst = 1'b0;
        send(32'h40A00000, 1'b0);
        send(32'h40C00000, 1'b0);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            alu_rst = ($urandom_range(0, 99) == 0);
            a_in    = rand_op();
            vld_in  = ($urandom_range(0, 4) != 0);
            rnd_in  = 1'($urandom);
            step();
        end
        alu_rst = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
